fir_ap_ctrl: RTL and testbench
==============================

# fir_ap_ctrl

AXI-Lite control and configuration front-end for the lab3 FIR engine. Decodes the host register map, writes and reads coefficients in the tap BRAM, and sequences a run through ap_start, ap_idle and ap_done. Arbitrates the single tap BRAM port between the host and the engine: the host owns it while idle, the engine owns it while running.

## Interface
- pADDR_WIDTH, 12, AXI-Lite and BRAM address width
- pDATA_WIDTH, 32, data width
- Tape_Num, 11, number of coefficients
- axis_clk  in  1  clock
- axis_rst_n  in  1  reset, asynchronous, active-low
- awvalid/awready  in/out  1  write address handshake
- awaddr  in  pADDR_WIDTH  write byte address
- wvalid/wready  in/out  1  write data handshake
- wdata  in  pDATA_WIDTH  write data
- arvalid/arready  in/out  1  read address handshake
- araddr  in  pADDR_WIDTH  read byte address
- rvalid/rready  out/in  1  read data handshake
- rdata  out  pDATA_WIDTH  read data
- tap_WE  out  4  tap BRAM byte write enables
- tap_EN  out  1  tap BRAM enable
- tap_Di  out  pDATA_WIDTH  tap BRAM write data
- tap_A  out  pADDR_WIDTH  tap BRAM byte address
- tap_Do  in  pDATA_WIDTH  tap BRAM read data (1-cycle latency)
- eng_start  out  1  one-cycle run-start pulse to the engine
- eng_tap_A  in  pADDR_WIDTH  engine tap read address
- eng_tap_Do  out  pDATA_WIDTH  tap data to the engine; wired straight from tap_Do
- eng_out_fire  in  1  engine output beat accepted (sm_tvalid && sm_tready)
- data_length  out  pDATA_WIDTH  programmed sample count

## Operation
- Register map (byte addresses):
  - 0x00 ap_ctrl. bit0 ap_start: write 1 to set; self-clears. bit1 ap_done: read-only, clear-on-read. bit2 ap_idle: read-only.
  - 0x10 data_length: read/write.
  - 0x20 to 0x20+4*(Tape_Num-1): coefficients. tap_A = addr-0x20.
  - Any other address: writes are dropped; reads return 0.
- FSM states:
  - IDLE: ap_idle=1; host owns the tap BRAM.
  - RUN: ap_idle=0; engine owns the tap BRAM. tap_A=eng_tap_A, tap_EN=1, tap_WE=0.
- IDLE->RUN: on an accepted write of 0x00 with wdata[0]=1.
  - ap_start=1 and eng_start=1 for exactly one cycle, then both clear.
  - Output counter cnt is cleared.
- RUN: cnt increments on each eng_out_fire. When an eng_out_fire brings cnt to data_length:
  - ap_done is set, ap_idle is set, and the FSM returns to IDLE.
- data_length=0: the start is accepted, but no eng_start is issued. ap_done and ap_idle are set the following cycle.
- ap_start write while in RUN: write is accepted and ignored.
- data_length write while in RUN: write is accepted, but the active run keeps the latched length.
- Write handshake:
  - awready and wready rise together for one cycle, only when awvalid && wvalid and the access is permitted.
  - The effect lands in that same cycle. For taps, this cycle has tap_EN=1, tap_WE=4'hF and tap_Di=wdata.
- Read handshake:
  - arready is a one-cycle pulse when arvalid, rvalid=0 and the access is permitted.
  - Tap reads drive tap_EN/tap_A in the arready cycle; rdata=tap_Do on the next cycle.
  - rvalid is held with rdata stable until rready. Only one read is outstanding at a time.
- Tap-region arbitration:
  - Tap-region reads and writes stall (no ready) while in RUN and are accepted after the return to IDLE.
  - Accesses to 0x00 and 0x10 are never stalled.
- Tap write and tap read arriving in the same IDLE cycle: the write wins and the read is accepted on the next cycle.
- ap_done:
  - Cleared when a read of 0x00 is accepted. The returned rdata shows the pre-clear value.
  - If a set and a clear land in the same cycle, the set wins.
- Address decode uses the full awaddr/araddr value; the low 2 bits must be 0, otherwise the access is treated as unmapped.

## Timing
- Reset values:
  - awready, wready, arready, rvalid, eng_start, tap_EN: 0.
  - tap_WE: 0. tap_A, tap_Di, rdata: 0.
  - data_length: 0. ap_start=0, ap_done=0, ap_idle=1. FSM in IDLE, cnt=0.
- Start write accepted in cycle N:
  - ap_idle reads 0 from N+1.
  - eng_start is high in N+1 only.
- Final eng_out_fire in cycle M: ap_done=1 and ap_idle=1 from M+1.
- Register read latency: arready in N, rvalid in N+1.
- Reset asserted mid-run: immediate return to reset values; the engine is re-sequenced only by a new start.

## Test plan
- Write taps 0..10 = {0,-10,-9,23,56,63,56,23,-9,-10,0}, then read back all 11 -> exact values, each rvalid one cycle after its arready.
- Write data_length=64, then ap_start -> eng_start pulses once, 0x00 reads 0x0 during the run; after 64 eng_out_fire, 0x00 reads 0x6, then the next read returns 0x4.
- During RUN, issue a tap write to 0x24 -> awready stays low until the run ends; the write then lands, and the engine sees tap_WE=0 throughout the run.
- During RUN, poll 0x00 and 0x10 -> answered without stall; tap_A tracks eng_tap_A.
- data_length=0, then ap_start -> no eng_start; ap_done=1 the following cycle.
- Assert reset two cycles after start -> all outputs at reset values and ap_ctrl reads 0x4.

Source files
------------

// File: rtl/fir_ap_ctrl.sv
// AXI-Lite register front-end for the FIR engine: ap_ctrl/data_length/taps, run sequencing, tap BRAM arbitration.
// Writes land in the handshake cycle; reads return one cycle after arready; tap-region accesses stall while running.
module fir_ap_ctrl #(
    parameter int pADDR_WIDTH = 12,
    parameter int pDATA_WIDTH = 32,
    parameter int Tape_Num    = 11
) (
    input  logic                   axis_clk,
    input  logic                   axis_rst_n,
    input  logic                   awvalid,
    output logic                   awready,
    input  logic [pADDR_WIDTH-1:0] awaddr,
    input  logic                   wvalid,
    output logic                   wready,
    input  logic [pDATA_WIDTH-1:0] wdata,
    input  logic                   arvalid,
    output logic                   arready,
    input  logic [pADDR_WIDTH-1:0] araddr,
    output logic                   rvalid,
    input  logic                   rready,
    output logic [pDATA_WIDTH-1:0] rdata,
    output logic [3:0]             tap_WE,
    output logic                   tap_EN,
    output logic [pDATA_WIDTH-1:0] tap_Di,
    output logic [pADDR_WIDTH-1:0] tap_A,
    input  logic [pDATA_WIDTH-1:0] tap_Do,
    output logic                   eng_start,
    input  logic [pADDR_WIDTH-1:0] eng_tap_A,
    output logic [pDATA_WIDTH-1:0] eng_tap_Do,
    input  logic                   eng_out_fire,
    output logic [pDATA_WIDTH-1:0] data_length
);
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    localparam logic [pADDR_WIDTH-1:0] ADDR_CTRL = '0;
    localparam logic [pADDR_WIDTH-1:0] ADDR_LEN  = pADDR_WIDTH'(16);
    localparam logic [pADDR_WIDTH-1:0] TAP_BASE  = pADDR_WIDTH'(32);
    localparam logic [pADDR_WIDTH-1:0] TAP_LAST  = pADDR_WIDTH'(32 + 4 * (Tape_Num - 1));

    function automatic logic is_tap(input logic [pADDR_WIDTH-1:0] a);
        return (a[1:0] == 2'b00) && (a >= TAP_BASE) && (a <= TAP_LAST);
    endfunction

    logic [0:0]             state;
    logic                   ap_start_q;
    logic                   ap_done_q;
    logic [pDATA_WIDTH-1:0] len_q;
    logic [pDATA_WIDTH-1:0] run_len_q;
    logic [pDATA_WIDTH-1:0] cnt_q;
    logic [pDATA_WIDTH-1:0] cnt_inc;
    logic                   eng_start_q;
    logic                   rvalid_q;
    logic                   rd_tap_q;
    logic [pDATA_WIDTH-1:0] rdata_q;

    logic                   running;
    logic                   wr_tap;
    logic                   rd_tap;
    logic                   wr_fire;
    logic                   rd_fire;
    logic                   start_req;
    logic                   done_set;
    logic                   done_clr;
    logic [pDATA_WIDTH-1:0] ctrl_val;
    logic [pDATA_WIDTH-1:0] rd_reg_val;

    assign running = (state == S_RUN);
    assign wr_tap  = is_tap(awaddr);
    assign rd_tap  = is_tap(araddr);
    assign cnt_inc = cnt_q + pDATA_WIDTH'(1);

    // A tap write in the same cycle holds the BRAM port, so a tap read waits one cycle.
    assign wr_fire = awvalid && wvalid && !(wr_tap && running);
    assign rd_fire = arvalid && !rvalid_q && !(rd_tap && (running || (wr_fire && wr_tap)));

    assign awready = wr_fire;
    assign wready  = wr_fire;
    assign arready = rd_fire;

    assign start_req = wr_fire && (awaddr == ADDR_CTRL) && wdata[0] && !running;
    assign done_clr  = rd_fire && (araddr == ADDR_CTRL);
    assign done_set  = (start_req && (len_q == '0)) ||
                       (running && eng_out_fire && (cnt_inc == run_len_q));

    always_comb begin
        ctrl_val    = '0;
        ctrl_val[0] = ap_start_q;
        ctrl_val[1] = ap_done_q;
        ctrl_val[2] = !running;
    end

    always_comb begin
        rd_reg_val = '0;
        if (araddr == ADDR_CTRL) begin
            rd_reg_val = ctrl_val;
        end else if (araddr == ADDR_LEN) begin
            rd_reg_val = len_q;
        end
    end

    always_comb begin
        tap_EN = 1'b0;
        tap_WE = 4'h0;
        tap_A  = '0;
        tap_Di = '0;
        if (running) begin
            tap_EN = 1'b1;
            tap_A  = eng_tap_A;
        end else if (wr_fire && wr_tap) begin
            tap_EN = 1'b1;
            tap_WE = 4'hF;
            tap_A  = awaddr - TAP_BASE;
            tap_Di = wdata;
        end else if (rd_fire && rd_tap) begin
            tap_EN = 1'b1;
            tap_A  = araddr - TAP_BASE;
        end
    end

    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            state       <= S_IDLE;
            ap_start_q  <= 1'b0;
            ap_done_q   <= 1'b0;
            len_q       <= '0;
            run_len_q   <= '0;
            cnt_q       <= '0;
            eng_start_q <= 1'b0;
        end else begin
            ap_start_q  <= start_req;
            eng_start_q <= start_req && (len_q != '0);
            if (start_req) begin
                cnt_q     <= '0;
                run_len_q <= len_q;
                if (len_q != '0) begin
                    state <= S_RUN;
                end
            end else if (running && eng_out_fire) begin
                cnt_q <= cnt_inc;
                if (cnt_inc == run_len_q) begin
                    state <= S_IDLE;
                end
            end
            if (done_set) begin
                ap_done_q <= 1'b1;
            end else if (done_clr) begin
                ap_done_q <= 1'b0;
            end
            if (wr_fire && (awaddr == ADDR_LEN)) begin
                len_q <= wdata;
            end
        end
    end

    // Tap data appears on tap_Do one cycle after arready; it is passed through once, then held in rdata_q.
    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            rvalid_q <= 1'b0;
            rd_tap_q <= 1'b0;
            rdata_q  <= '0;
        end else if (rd_fire) begin
            rvalid_q <= 1'b1;
            rd_tap_q <= rd_tap;
            rdata_q  <= rd_tap ? '0 : rd_reg_val;
        end else begin
            if (rd_tap_q) begin
                rdata_q  <= tap_Do;
                rd_tap_q <= 1'b0;
            end
            if (rvalid_q && rready) begin
                rvalid_q <= 1'b0;
            end
        end
    end

    assign rvalid      = rvalid_q;
    assign rdata       = rd_tap_q ? tap_Do : rdata_q;
    assign eng_start   = eng_start_q;
    assign eng_tap_Do  = tap_Do;
    assign data_length = len_q;

endmodule

// File: tb/tb_fir_ap_ctrl.sv
// Directed bench for fir_ap_ctrl: tap BRAM model, register map, run sequencing and arbitration.
module tb_fir_ap_ctrl;
    localparam int AW = 12;
    localparam int DW = 32;

    logic          axis_clk = 1'b0;
    logic          axis_rst_n = 1'b0;
    logic          awvalid, awready, wvalid, wready, arvalid, arready, rvalid, rready;
    logic [AW-1:0] awaddr, araddr, tap_A, eng_tap_A;
    logic [DW-1:0] wdata, rdata, tap_Di, eng_tap_Do, data_length;
    logic [DW-1:0] tap_Do = '0;
    logic [3:0]    tap_WE;
    logic          tap_EN, eng_start, eng_out_fire;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int es_cnt = 0;
    int run_bad = 0;
    int m_cyc = 0;
    bit run_active = 1'b0;
    logic [DW-1:0] mem [0:1023];

    fir_ap_ctrl #(.pADDR_WIDTH(AW), .pDATA_WIDTH(DW), .Tape_Num(11)) dut (
        .axis_clk(axis_clk), .axis_rst_n(axis_rst_n),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
        .wvalid(wvalid), .wready(wready), .wdata(wdata),
        .arvalid(arvalid), .arready(arready), .araddr(araddr),
        .rvalid(rvalid), .rready(rready), .rdata(rdata),
        .tap_WE(tap_WE), .tap_EN(tap_EN), .tap_Di(tap_Di), .tap_A(tap_A), .tap_Do(tap_Do),
        .eng_start(eng_start), .eng_tap_A(eng_tap_A), .eng_tap_Do(eng_tap_Do),
        .eng_out_fire(eng_out_fire), .data_length(data_length)
    );

    always #5 axis_clk = ~axis_clk;

    always @(posedge axis_clk) cyc <= cyc + 1;

    always @(posedge axis_clk) begin
        if (tap_EN) begin
            if (tap_WE == 4'hF) mem[tap_A[11:2]] <= tap_Di;
            tap_Do <= mem[tap_A[11:2]];
        end
    end

    always @(posedge axis_clk) if (eng_start) es_cnt <= es_cnt + 1;

    // While the engine owns the port, the host must never reach it.
    always @(negedge axis_clk) begin
        #2;
        if (run_active && (tap_WE != 4'h0 || !tap_EN || tap_A != eng_tap_A)) run_bad = run_bad + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, output int fc);
        int n;
        bit tap;
        tap = (a[1:0] == 2'b00) && (a >= 12'h20) && (a <= 12'h48);
        n = 0;
        @(negedge axis_clk);
        awaddr = a; wdata = d; awvalid = 1'b1; wvalid = 1'b1;
        #1;
        while (!(awready && wready) && n < 400) begin
            @(negedge axis_clk); #1; n++;
        end
        fc = cyc;
        check("wr_handshake", {awready, wready}, 2'b11);
        if (tap) begin
            check("wr_tap_ctl", {tap_EN, tap_WE, tap_A}, {1'b1, 4'hF, a - 12'h20});
            check("wr_tap_di", tap_Di, d);
        end else if (!run_active) begin
            check("wr_notap_en", tap_EN, 1'b0);
        end
        @(posedge axis_clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
    endtask

    task automatic rd(input logic [AW-1:0] a, output logic [DW-1:0] d, output int ac);
        int n;
        n = 0;
        @(negedge axis_clk);
        araddr = a; arvalid = 1'b1;
        #1;
        while (!arready && n < 400) begin
            @(negedge axis_clk); #1; n++;
        end
        ac = cyc;
        check("rd_arready", arready, 1'b1);
        @(posedge axis_clk); #1;
        arvalid = 1'b0;
        @(negedge axis_clk);
        check("rd_latency", rvalid, 1'b1);
        d = rdata;
        @(negedge axis_clk);
        check("rd_hold", {rvalid, rdata}, {1'b1, d});
        rready = 1'b1;
        @(posedge axis_clk); #1;
        rready = 1'b0;
        check("rd_drop", rvalid, 1'b0);
    endtask

    task automatic check_reset_outs(input string tag);
        check({tag, "_ctl"}, {awready, wready, arready, rvalid, eng_start, tap_EN, tap_WE}, '0);
        check({tag, "_tapA"}, tap_A, '0);
        check({tag, "_tapDi"}, tap_Di, '0);
        check({tag, "_rdata"}, rdata, '0);
        check({tag, "_len"}, data_length, '0);
    endtask

    initial begin
        int taps [11] = '{0, -10, -9, 23, 56, 63, 56, 23, -9, -10, 0};
        logic [DW-1:0] d;
        int fc, ac, es0;

        awvalid = 0; wvalid = 0; arvalid = 0; rready = 0; eng_out_fire = 0;
        awaddr = '0; araddr = '0; wdata = '0; eng_tap_A = '0;

        repeat (3) @(negedge axis_clk);
        #1;
        check_reset_outs("reset");
        axis_rst_n = 1'b1;
        rd(12'h000, d, ac); check("reset_ctrl", d, 32'h4);

        for (int i = 0; i < 11; i++) wr(AW'(12'h20 + 4 * i), 32'(taps[i]), fc);
        for (int i = 0; i < 11; i++) begin
            rd(AW'(12'h20 + 4 * i), d, ac);
            check($sformatf("tap_rd%0d", i), d, 32'(taps[i]));
        end

        wr(12'h008, 32'hDEAD_BEEF, fc);
        rd(12'h008, d, ac); check("unmapped_08", d, 0);
        rd(12'h022, d, ac); check("misaligned_22", d, 0);
        rd(12'h012, d, ac); check("misaligned_12", d, 0);
        wr(12'h04C, 32'h7777, fc);
        rd(12'h04C, d, ac); check("past_taps_4c", d, 0);

        fork
            wr(12'h028, 32'h55, fc);
            rd(12'h02C, d, ac);
        join
        check("conflict_order", ac, fc + 1);
        check("conflict_rdata", d, 32'd23);
        rd(12'h028, d, ac); check("conflict_wr_landed", d, 32'h55);

        wr(12'h010, 32'd64, fc);
        rd(12'h010, d, ac); check("len_rd", d, 32'd64);
        check("len_port", data_length, 32'd64);
        es0 = es_cnt;
        wr(12'h000, 32'h1, fc);
        check("eng_start_n1", eng_start, 1'b1);
        run_active = 1'b1;
        @(posedge axis_clk); #1;
        check("eng_start_n2", eng_start, 1'b0);
        fork
            begin
                for (int i = 0; i < 64; i++) begin
                    @(negedge axis_clk);
                    eng_tap_A = AW'((i % 11) * 4);
                    eng_out_fire = 1'b1;
                    m_cyc = cyc;
                    @(posedge axis_clk);
                    if (i == 63) run_active = 1'b0;
                    @(negedge axis_clk);
                    eng_out_fire = 1'b0;
                end
            end
            begin
                rd(12'h000, d, ac); check("run_ctrl", d, 0);
                rd(12'h010, d, ac); check("run_len", d, 32'd64);
                wr(12'h010, 32'd5, fc);
                wr(12'h000, 32'h1, fc);
                rd(12'h010, d, ac); check("run_len_new", d, 32'd5);
                repeat (40) @(negedge axis_clk);
                rd(12'h000, d, ac); check("run_latched_len", d, 0);
                wr(12'h024, 32'h1234, fc);
                check("stall_until_idle", fc, m_cyc + 1);
            end
        join
        check("run_tap_owner", run_bad, 0);
        check("one_eng_start", es_cnt - es0, 1);
        rd(12'h024, d, ac); check("stalled_wr_landed", d, 32'h1234);
        rd(12'h000, d, ac); check("done_ctrl", d, 32'h6);
        rd(12'h000, d, ac); check("done_cleared", d, 32'h4);

        wr(12'h010, 32'd0, fc);
        es0 = es_cnt;
        wr(12'h000, 32'h1, fc);
        repeat (2) @(negedge axis_clk);
        check("zero_len_no_start", es_cnt - es0, 0);
        rd(12'h000, d, ac); check("zero_len_done", d, 32'h6);
        rd(12'h000, d, ac); check("zero_len_cleared", d, 32'h4);

        wr(12'h010, 32'd64, fc);
        es0 = es_cnt;
        wr(12'h000, 32'h1, fc);
        @(posedge axis_clk); #1;
        axis_rst_n = 1'b0;
        #1;
        check_reset_outs("rst_midrun");
        repeat (2) @(negedge axis_clk);
        axis_rst_n = 1'b1;
        rd(12'h000, d, ac); check("rst_midrun_ctrl", d, 32'h4);
        repeat (10) @(negedge axis_clk);
        check("rst_no_restart", es_cnt - es0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog expired");
    end

endmodule
